// File: rtl/execute_stage.sv
// rtl/execute_stage.sv - execute stage: single-cycle ALU plus optional 32-step shift-add multiplier (EXECUTE_STAGE_MULT_EN)
module execute_stage (
  input  logic         clk,
  input  logic         reset,
  input  logic [107:0] id_ex,
  input  logic         in_valid,
  output logic         stall,
  output logic [75:0]  ex_mem,
  output logic         ex_valid
);

  typedef enum logic {IDLE = 1'b0, MUL = 1'b1} state_t;

  state_t state, next_state;

  logic [5:0]  op;
  logic [31:0] a, b;
  logic [4:0]  dest;
  logic [31:0] alu_res;
  logic        alu_known;
  logic        unused_bits;

  assign op   = id_ex[107:102];
  assign a    = id_ex[101:70];
  assign b    = id_ex[69:38];
  assign dest = id_ex[37:33];

  // is_r_type and the reserved field carry nothing the datapath needs
  assign unused_bits = ^{id_ex[32:0], state};

  // Single-cycle ALU; opcode 5 falls to default and is handled by the multiplier when present
  always_comb begin
    alu_res   = 32'd0;
    alu_known = 1'b1;
    case (op)
      6'd0, 6'd8:  alu_res = a + b;
      6'd1, 6'd9:  alu_res = a - b;
      6'd2:        alu_res = a & b;
      6'd3:        alu_res = a | b;
      6'd4, 6'd10: alu_res = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      default:     alu_known = 1'b0;
    endcase
  end

`ifdef EXECUTE_STAGE_MULT_EN
  logic        start_mul;
  logic [4:0]  cnt;
  logic [31:0] acc, mcand, mplier, m_b, acc_next;
  logic [4:0]  m_dest;

  assign start_mul = (state == IDLE) && in_valid && (op == 6'd5);
  assign acc_next  = acc + (mplier[0] ? mcand : 32'd0);

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= next_state;
  end

  // Next state: enter MUL on a multiply, leave after the step taken with counter at 31
  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (start_mul) next_state = MUL;
      MUL:     if (cnt == 5'd31) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Stall output: hold upstream until the cycle of the final step
  always_comb begin
    stall = start_mul || ((state == MUL) && (cnt != 5'd31));
  end

  // Multiplier datapath: one shift-add step per edge while in MUL
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt    <= 5'd0;
      acc    <= 32'd0;
      mcand  <= 32'd0;
      mplier <= 32'd0;
      m_b    <= 32'd0;
      m_dest <= 5'd0;
    end else if (state == MUL) begin
      acc    <= acc_next;
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
      cnt    <= cnt + 5'd1;
    end else if (start_mul) begin
      acc    <= 32'd0;
      mcand  <= a;
      mplier <= b;
      m_b    <= b;
      m_dest <= dest;
      cnt    <= 5'd0;
    end
  end

  // Result register: ALU results in IDLE, multiplier result on the last step
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ex_mem   <= 76'd0;
      ex_valid <= 1'b0;
    end else if (state == MUL) begin
      if (cnt == 5'd31) begin
        ex_mem   <= {6'd5, acc_next, m_dest, (m_dest != 5'd0), m_b};
        ex_valid <= 1'b1;
      end else begin
        ex_valid <= 1'b0;
      end
    end else if (start_mul) begin
      ex_valid <= 1'b0;
    end else if (in_valid) begin
      ex_mem   <= {op, alu_res, dest, alu_known && (dest != 5'd0), b};
      ex_valid <= 1'b1;
    end else begin
      ex_valid <= 1'b0;
    end
  end
`else
  // State register: without the multiplier the stage never leaves IDLE
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= next_state;
  end

  // Next state: always IDLE
  always_comb begin
    next_state = IDLE;
  end

  // Stall output: nothing ever takes more than one cycle
  always_comb begin
    stall = 1'b0;
  end

  // Result register: every valid instruction completes in one cycle
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ex_mem   <= 76'd0;
      ex_valid <= 1'b0;
    end else if (in_valid) begin
      ex_mem   <= {op, alu_res, dest, alu_known && (dest != 5'd0), b};
      ex_valid <= 1'b1;
    end else begin
      ex_valid <= 1'b0;
    end
  end
`endif

endmodule

// File: tb/tb_execute_stage.sv
// tb/tb_execute_stage.sv - directed self-checking bench for execute_stage
module tb_execute_stage;

  logic         clk;
  logic         reset;
  logic [107:0] id_ex;
  logic         in_valid;
  logic         stall;
  logic [75:0]  ex_mem;
  logic         ex_valid;

  int errors = 0;
  int checks = 0;

  execute_stage dut (
    .clk      (clk),
    .reset    (reset),
    .id_ex    (id_ex),
    .in_valid (in_valid),
    .stall    (stall),
    .ex_mem   (ex_mem),
    .ex_valid (ex_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [107:0] mk(input logic [5:0] op, input logic [31:0] a,
                                      input logic [31:0] b, input logic [4:0] d);
    return {op, a, b, d, 1'b0, 32'hDEAD_BEEF};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; in_valid = 1'b0; id_ex = '0;
    tick(); tick();
    checks++; if (ex_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got=%0b exp=0", ex_valid); end
    checks++; if (ex_mem !== 76'd0) begin errors++; $display("FAIL reset_mem got=%h exp=0", ex_mem); end
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL reset_stall got=%0b exp=0", stall); end
    reset = 1'b0;
    tick();
  endtask

  task automatic test_add();
    id_ex = mk(6'd0, 32'h7FFF_FFFF, 32'h1, 5'd3); in_valid = 1'b1;
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL add_stall got=%0b exp=0", stall); end
    tick();
    checks++; if (ex_valid !== 1'b1) begin errors++; $display("FAIL add_valid got=%0b exp=1", ex_valid); end
    checks++; if (ex_mem !== {6'd0, 32'h8000_0000, 5'd3, 1'b1, 32'h1})
      begin errors++; $display("FAIL add_mem got=%h exp=%h", ex_mem, {6'd0, 32'h8000_0000, 5'd3, 1'b1, 32'h1}); end
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL add_stall_after got=%0b exp=0", stall); end
    in_valid = 1'b0; id_ex = mk(6'd1, 32'h5, 32'h5, 5'd9);
    tick();
    checks++; if (ex_valid !== 1'b0) begin errors++; $display("FAIL idle_valid got=%0b exp=0", ex_valid); end
    checks++; if (ex_mem !== {6'd0, 32'h8000_0000, 5'd3, 1'b1, 32'h1})
      begin errors++; $display("FAIL idle_hold got=%h", ex_mem); end
  endtask

  task automatic test_alu_ops();
    logic [5:0]  ops  [6] = '{6'd10, 6'd4, 6'd1, 6'd2, 6'd3, 6'd9};
    logic [31:0] as   [6] = '{32'hFFFF_FFFF, 32'h1, 32'h0, 32'hF0F0_1234, 32'hF000_0000, 32'h10};
    logic [31:0] bs   [6] = '{32'h1, 32'hFFFF_FFFF, 32'h1, 32'h0FF0_FFFF, 32'h0000_000F, 32'h11};
    logic [31:0] exps [6] = '{32'h1, 32'h0, 32'hFFFF_FFFF, 32'h00F0_1234, 32'hF000_000F, 32'hFFFF_FFFF};
    for (int i = 0; i < 6; i++) begin
      id_ex = mk(ops[i], as[i], bs[i], 5'd4); in_valid = 1'b1;
      tick();
      checks++;
      if (ex_valid !== 1'b1 || ex_mem !== {ops[i], exps[i], 5'd4, 1'b1, bs[i]}) begin
        errors++;
        $display("FAIL alu_op%0d valid=%0b got=%h exp=%h", ops[i], ex_valid, ex_mem, {ops[i], exps[i], 5'd4, 1'b1, bs[i]});
      end
    end
    in_valid = 1'b0;
    tick();
  endtask

  task automatic test_unknown();
    id_ex = mk(6'd0, 32'h3, 32'h4, 5'd0); in_valid = 1'b1;
    tick();
    checks++; if (ex_mem !== {6'd0, 32'h7, 5'd0, 1'b0, 32'h4})
      begin errors++; $display("FAIL dest0 got=%h exp=%h", ex_mem, {6'd0, 32'h7, 5'd0, 1'b0, 32'h4}); end
    id_ex = mk(6'h3F, 32'h3, 32'h4, 5'd6);
    tick();
    checks++; if (ex_valid !== 1'b1 || ex_mem !== {6'h3F, 32'h0, 5'd6, 1'b0, 32'h4})
      begin errors++; $display("FAIL unknown valid=%0b got=%h", ex_valid, ex_mem); end
    in_valid = 1'b0;
    tick();
  endtask

`ifdef EXECUTE_STAGE_MULT_EN
  task automatic test_mul();
    int edges = 0;
    int stall_cnt = 0;
    logic s;
    logic got = 1'b0;
    id_ex = mk(6'd5, 32'h0001_0001, 32'h0001_0001, 5'd7); in_valid = 1'b1;
    while (edges < 40 && !got) begin
      s = stall;
      if (s) stall_cnt++;
      tick();
      edges++;
      if (!s) id_ex = mk(6'd0, 32'd5, 32'd6, 5'd2);
      if (ex_valid) got = 1'b1;
    end
    checks++; if (stall_cnt != 32) begin errors++; $display("FAIL mul_stall_cycles got=%0d exp=32", stall_cnt); end
    checks++; if (edges != 33) begin errors++; $display("FAIL mul_latency got=%0d exp=33 (edge N+32)", edges); end
    checks++; if (ex_mem !== {6'd5, 32'h0002_0001, 5'd7, 1'b1, 32'h0001_0001})
      begin errors++; $display("FAIL mul_result got=%h exp=%h", ex_mem, {6'd5, 32'h0002_0001, 5'd7, 1'b1, 32'h0001_0001}); end
    tick();
    checks++; if (ex_valid !== 1'b1 || ex_mem !== {6'd0, 32'd11, 5'd2, 1'b1, 32'd6})
      begin errors++; $display("FAIL mul_follow_add valid=%0b got=%h", ex_valid, ex_mem); end
    in_valid = 1'b0;
    tick();
  endtask

  task automatic test_reset_mid_mul();
    logic seen = 1'b0;
    id_ex = mk(6'd5, 32'd3, 32'd4, 5'd8); in_valid = 1'b1;
    tick();
    repeat (10) tick();
    in_valid = 1'b0;
    reset = 1'b1;
    #2;
    checks++; if (ex_valid !== 1'b0 || ex_mem !== 76'd0)
      begin errors++; $display("FAIL abort_clear valid=%0b mem=%h exp 0/0", ex_valid, ex_mem); end
    tick();
    reset = 1'b0;
    #1;
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL abort_stall got=%0b exp=0", stall); end
    for (int i = 0; i < 40; i++) begin
      tick();
      if (ex_valid) seen = 1'b1;
    end
    checks++; if (seen !== 1'b0) begin errors++; $display("FAIL abort_no_result got=%0b exp=0", seen); end
    id_ex = mk(6'd0, 32'd10, 32'd20, 5'd1); in_valid = 1'b1;
    tick();
    checks++; if (ex_valid !== 1'b1 || ex_mem !== {6'd0, 32'd30, 5'd1, 1'b1, 32'd20})
      begin errors++; $display("FAIL abort_then_add valid=%0b got=%h", ex_valid, ex_mem); end
    in_valid = 1'b0;
    tick();
  endtask
`else
  task automatic test_mul();
    id_ex = mk(6'd5, 32'h0001_0001, 32'h0001_0001, 5'd7); in_valid = 1'b1;
    #1;
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL nomul_stall got=%0b exp=0", stall); end
    tick();
    checks++; if (ex_valid !== 1'b1 || ex_mem !== {6'd5, 32'h0, 5'd7, 1'b0, 32'h0001_0001})
      begin errors++; $display("FAIL nomul_result valid=%0b got=%h", ex_valid, ex_mem); end
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL nomul_stall_after got=%0b exp=0", stall); end
    in_valid = 1'b0;
    tick();
  endtask

  task automatic test_reset_mid_mul();
    id_ex = mk(6'd0, 32'd10, 32'd20, 5'd1); in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    reset = 1'b1;
    #2;
    checks++; if (ex_valid !== 1'b0 || ex_mem !== 76'd0)
      begin errors++; $display("FAIL async_reset valid=%0b mem=%h exp 0/0", ex_valid, ex_mem); end
    tick();
    reset = 1'b0;
    id_ex = mk(6'd0, 32'd10, 32'd20, 5'd1); in_valid = 1'b1;
    tick();
    checks++; if (ex_valid !== 1'b1 || ex_mem !== {6'd0, 32'd30, 5'd1, 1'b1, 32'd20})
      begin errors++; $display("FAIL reset_then_add valid=%0b got=%h", ex_valid, ex_mem); end
    in_valid = 1'b0;
    tick();
  endtask
`endif

  initial begin
    test_reset();
    test_add();
    test_alu_ops();
    test_unknown();
    test_mul();
    test_reset_mid_mul();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
